// File: rtl/fetch_if.sv
// Fetch-side bundle: ROM address/data, decode redirect controls and IF/ID outputs.
interface fetch_if #(
    parameter int AW = 9
);
    logic [AW-1:0] rom_a;
    logic [31:0]   rom_i;
    logic          stall;
    logic          br_take;
    logic [AW-1:0] br_tgt;
    logic          annul;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic          fault;

    modport master (
        output rom_a, if_valid, if_instr, if_pc, pc, npc, fault,
        input  rom_i, stall, br_take, br_tgt, annul
    );

    modport slave (
        input  rom_a, if_valid, if_instr, if_pc, pc, npc, fault,
        output rom_i, stall, br_take, br_tgt, annul
    );
endinterface

// File: rtl/fetch_sequencer.sv
// SPARC instruction-fetch controller: PC/nPC delayed-branch sequencing, annul,
// stall with pending-redirect capture, and sticky halt on misaligned targets.
module fetch_sequencer #(
    parameter int            AW       = 9,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic R,
    fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, npc_q, npc_d;
    logic          if_valid_q, if_valid_d;
    logic [31:0]   if_instr_q, if_instr_d;
    logic [AW-1:0] if_pc_q, if_pc_d;
    logic          fault_q, fault_d;
    logic          pend_br_q, pend_br_d;
    logic [AW-1:0] pend_tgt_q, pend_tgt_d;
    logic          pend_annul_q, pend_annul_d;
    logic          squash_q, squash_d;

    logic          redirect;
    logic [AW-1:0] tgt;
    logic          ann;

    // A live br_take takes precedence over a redirect left pending by a stall.
    assign redirect = bus.br_take | pend_br_q;
    assign tgt      = bus.br_take ? bus.br_tgt : pend_tgt_q;
    assign ann      = bus.br_take ? bus.annul  : pend_annul_q;

    always_ff @(posedge clk) begin
        if (R) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            npc_q        <= RESET_PC + AW'(4);
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            fault_q      <= 1'b0;
            pend_br_q    <= 1'b0;
            pend_tgt_q   <= '0;
            pend_annul_q <= 1'b0;
            squash_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            npc_q        <= npc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            fault_q      <= fault_d;
            pend_br_q    <= pend_br_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_annul_q <= pend_annul_d;
            squash_q     <= squash_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        fault_d      = fault_q;
        pend_br_d    = pend_br_q;
        pend_tgt_d   = pend_tgt_q;
        pend_annul_d = pend_annul_q;
        squash_d     = squash_q;

        unique case (state_q)
            BOOT: begin
                if_valid_d = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                if (bus.stall) begin
                    if (bus.br_take) begin
                        pend_br_d    = 1'b1;
                        pend_tgt_d   = bus.br_tgt;
                        pend_annul_d = bus.annul;
                    end
                end else if (redirect && (tgt[1:0] != 2'b00)) begin
                    fault_d      = 1'b1;
                    if_valid_d   = 1'b0;
                    pend_br_d    = 1'b0;
                    pend_annul_d = 1'b0;
                    state_d      = HALT;
                end else begin
                    if_instr_d   = bus.rom_i;
                    if_pc_d      = pc_q;
                    if_valid_d   = ~squash_q;
                    pc_d         = npc_q;
                    npc_d        = redirect ? tgt : npc_q + AW'(4);
                    // Annul kills the word at old nPC, captured on the next advance.
                    squash_d     = redirect & ann;
                    pend_br_d    = 1'b0;
                    pend_annul_d = 1'b0;
                end
            end
            HALT: begin
                if_valid_d = 1'b0;
            end
            default: state_d = BOOT;
        endcase
    end

    assign bus.rom_a    = pc_q;
    assign bus.pc       = pc_q;
    assign bus.npc      = npc_q;
    assign bus.if_valid = if_valid_q;
    assign bus.if_instr = if_instr_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.fault    = fault_q;
endmodule
